// File: rtl/rv64i_pkg.sv
// Shared RV64I encodings and ALU operation set for the single-cycle datapath.
package rv64i_pkg;

  localparam int XLEN = 64;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Immediate shifts use a 6-bit shamt, so only instr[31:26] qualifies them.
  localparam logic [5:0] F6_SRL = 6'b000000;
  localparam logic [5:0] F6_SRA = 6'b010000;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND,
    ALU_PASSB
  } alu_op_e;

endpackage

// File: rtl/regfile.sv
// 32 x XLEN integer register file: two combinational reads, one synchronous write.
module regfile
  import rv64i_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  input  logic [4:0]      rd_addr,
  input  logic            we,
  input  logic [XLEN-1:0] rd_data,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data
);

  logic [XLEN-1:0] X [0:31];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) X[i] <= '0;
    end else if (we && (rd_addr != 5'd0)) begin
      X[rd_addr] <= rd_data;
    end
  end

  // Reads see the pre-edge contents, so read-during-write returns the old value.
  assign rs1_data = (rs1_addr == 5'd0) ? '0 : X[rs1_addr];
  assign rs2_data = (rs2_addr == 5'd0) ? '0 : X[rs2_addr];

endmodule

// File: rtl/datapath.sv
// Single-cycle RV64I integer datapath: OP, OP-IMM and LUI, one instruction per clock.
module datapath #(
  parameter int XLEN    = 64,
  parameter int PC_STEP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instruction,
  output logic [XLEN-1:0]  pc_out
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rs1, rs2, rd;

  assign opcode = instruction[6:0];
  assign rd     = instruction[11:7];
  assign funct3 = instruction[14:12];
  assign rs1    = instruction[19:15];
  assign rs2    = instruction[24:20];
  assign funct7 = instruction[31:25];

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] rs1_data, rs2_data, imm_val, alu_b, alu_y;
  logic [5:0]      shamt;
  logic            use_imm, reg_we;
  rv64i_pkg::alu_op_e alu_op;

  always_ff @(posedge clk) begin
    if (rst) pc <= '0;
    else     pc <= pc + XLEN'(PC_STEP);
  end

  assign pc_out = pc;

  always_comb begin
    alu_op  = rv64i_pkg::ALU_ADD;
    use_imm = 1'b0;
    reg_we  = 1'b0;
    case (opcode)
      rv64i_pkg::OPC_OP_IMM: begin
        use_imm = 1'b1;
        reg_we  = 1'b1;
        case (funct3)
          rv64i_pkg::F3_ADD_SUB: alu_op = rv64i_pkg::ALU_ADD;
          rv64i_pkg::F3_SLT:     alu_op = rv64i_pkg::ALU_SLT;
          rv64i_pkg::F3_SLTU:    alu_op = rv64i_pkg::ALU_SLTU;
          rv64i_pkg::F3_XOR:     alu_op = rv64i_pkg::ALU_XOR;
          rv64i_pkg::F3_OR:      alu_op = rv64i_pkg::ALU_OR;
          rv64i_pkg::F3_AND:     alu_op = rv64i_pkg::ALU_AND;
          rv64i_pkg::F3_SLL: begin
            alu_op = rv64i_pkg::ALU_SLL;
            reg_we = (instruction[31:26] == rv64i_pkg::F6_SRL);
          end
          default: begin
            if (instruction[31:26] == rv64i_pkg::F6_SRL)      alu_op = rv64i_pkg::ALU_SRL;
            else if (instruction[31:26] == rv64i_pkg::F6_SRA) alu_op = rv64i_pkg::ALU_SRA;
            else                                              reg_we = 1'b0;
          end
        endcase
      end
      rv64i_pkg::OPC_OP: begin
        reg_we = (funct7 == rv64i_pkg::F7_BASE);
        case (funct3)
          rv64i_pkg::F3_ADD_SUB: begin
            if (funct7 == rv64i_pkg::F7_ALT) begin
              alu_op = rv64i_pkg::ALU_SUB;
              reg_we = 1'b1;
            end else begin
              alu_op = rv64i_pkg::ALU_ADD;
            end
          end
          rv64i_pkg::F3_SRL_SRA: begin
            if (funct7 == rv64i_pkg::F7_ALT) begin
              alu_op = rv64i_pkg::ALU_SRA;
              reg_we = 1'b1;
            end else begin
              alu_op = rv64i_pkg::ALU_SRL;
            end
          end
          rv64i_pkg::F3_SLL:  alu_op = rv64i_pkg::ALU_SLL;
          rv64i_pkg::F3_SLT:  alu_op = rv64i_pkg::ALU_SLT;
          rv64i_pkg::F3_SLTU: alu_op = rv64i_pkg::ALU_SLTU;
          rv64i_pkg::F3_XOR:  alu_op = rv64i_pkg::ALU_XOR;
          rv64i_pkg::F3_OR:   alu_op = rv64i_pkg::ALU_OR;
          default:            alu_op = rv64i_pkg::ALU_AND;
        endcase
      end
      rv64i_pkg::OPC_LUI: begin
        use_imm = 1'b1;
        reg_we  = 1'b1;
        alu_op  = rv64i_pkg::ALU_PASSB;
      end
      default: reg_we = 1'b0;
    endcase
  end

  assign imm_val = (opcode == rv64i_pkg::OPC_LUI)
                 ? {{(XLEN-32){instruction[31]}}, instruction[31:12], 12'b0}
                 : {{(XLEN-12){instruction[31]}}, instruction[31:20]};

  assign alu_b = use_imm ? imm_val : rs2_data;
  // For immediate shifts alu_b[5:0] is instr[25:20]; for register shifts it is rs2[5:0].
  assign shamt = alu_b[5:0];

  always_comb begin
    alu_y = '0;
    case (alu_op)
      rv64i_pkg::ALU_ADD:   alu_y = rs1_data + alu_b;
      rv64i_pkg::ALU_SUB:   alu_y = rs1_data - alu_b;
      rv64i_pkg::ALU_SLL:   alu_y = rs1_data << shamt;
      rv64i_pkg::ALU_SLT:   alu_y = {{(XLEN-1){1'b0}}, ($signed(rs1_data) < $signed(alu_b))};
      rv64i_pkg::ALU_SLTU:  alu_y = {{(XLEN-1){1'b0}}, (rs1_data < alu_b)};
      rv64i_pkg::ALU_XOR:   alu_y = rs1_data ^ alu_b;
      rv64i_pkg::ALU_SRL:   alu_y = rs1_data >> shamt;
      rv64i_pkg::ALU_SRA:   alu_y = $signed(rs1_data) >>> shamt;
      rv64i_pkg::ALU_OR:    alu_y = rs1_data | alu_b;
      rv64i_pkg::ALU_AND:   alu_y = rs1_data & alu_b;
      rv64i_pkg::ALU_PASSB: alu_y = alu_b;
      default:              alu_y = '0;
    endcase
  end

  regfile REGFILE (
    .clk      (clk),
    .rst      (rst),
    .rs1_addr (rs1),
    .rs2_addr (rs2),
    .rd_addr  (rd),
    .we       (reg_we),
    .rd_data  (alu_y),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data)
  );

endmodule

// File: tb/tb_datapath.sv
// Directed-vector bench for the single-cycle RV64I datapath.
module tb_datapath;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic [31:0] instruction;
  logic [63:0] pc_out;

  int checks = 0;
  int errors = 0;
  logic [63:0] pc_before;

  datapath #(.XLEN(64), .PC_STEP(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .instruction (instruction),
    .pc_out      (pc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, OP_I};
  endfunction

  function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, OP_R};
  endfunction

  function automatic logic [31:0] lui(input logic [19:0] imm, input logic [4:0] rd);
    return {imm, rd, 7'b0110111};
  endfunction

  // Present on the falling edge, execute on the rising edge, sample 1 ns later.
  task automatic step(input logic [31:0] ins);
    @(negedge clk);
    instruction = ins;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(NOP);
    rst = 1'b0;
  endtask

  function automatic logic [63:0] xr(input int idx);
    return dut.REGFILE.X[idx];
  endfunction

  initial begin
    rst = 1'b1;
    instruction = NOP;

    // 1: reset then addi x5,x0,12
    do_reset();
    check("reset_pc", pc_out, 64'd0);
    check("reset_x5", xr(5), 64'd0);
    step(32'h00C0_0293);
    check("addi_x5", xr(5), 64'd12);
    check("addi_pc", pc_out, 64'd4);

    // 2: add
    do_reset();
    step(32'h0050_0093);
    step(32'h0060_0113);
    step(32'h0020_81B3);
    check("add_x3", xr(3), 64'd11);
    check("add_pc", pc_out, 64'd12);

    // 3: sub
    do_reset();
    step(i_type(12'd15, 5'd0, 3'b000, 5'd6));
    step(i_type(12'd5,  5'd0, 3'b000, 5'd7));
    step(32'h4063_8233);
    check("sub_x4", xr(4), 64'hFFFF_FFFF_FFFF_FFF6);
    check("sub_pc", pc_out, 64'd12);

    // 4: logic ops
    step(i_type(12'h00F, 5'd0, 3'b000, 5'd6));
    step(i_type(12'h055, 5'd0, 3'b000, 5'd7));
    step(r_type(7'b0000000, 5'd6, 5'd7, 3'b111, 5'd8));
    check("and_x8", xr(8), 64'h05);
    step(i_type(12'h0F0, 5'd0, 3'b000, 5'd20));
    step(i_type(12'h055, 5'd0, 3'b000, 5'd21));
    step(r_type(7'b0000000, 5'd20, 5'd21, 3'b110, 5'd20));
    check("or_x20", xr(20), 64'hF5);
    step(i_type(12'h0FF, 5'd20, 3'b100, 5'd22));
    check("xori_x22", xr(22), 64'h0A);
    // rd == rs1: source is the pre-edge value
    step(i_type(12'd1, 5'd20, 3'b000, 5'd20));
    check("rdw_x20", xr(20), 64'hF6);

    // 5: edge cases
    step(i_type(12'd7, 5'd0, 3'b000, 5'd0));
    check("x0_hold", xr(0), 64'd0);
    step(i_type(12'hFFF, 5'd0, 3'b000, 5'd9));
    check("addi_m1", xr(9), 64'hFFFF_FFFF_FFFF_FFFF);
    step(i_type(12'h404, 5'd9, 3'b101, 5'd10));
    check("srai", xr(10), 64'hFFFF_FFFF_FFFF_FFFF);
    step(i_type(12'h03C, 5'd9, 3'b101, 5'd11));
    check("srli", xr(11), 64'hF);
    step(r_type(7'b0000000, 5'd0, 5'd9, 3'b010, 5'd12));
    check("slt", xr(12), 64'd1);
    step(r_type(7'b0000000, 5'd0, 5'd9, 3'b011, 5'd13));
    check("sltu", xr(13), 64'd0);
    step(lui(20'h80000, 5'd14));
    check("lui", xr(14), 64'hFFFF_FFFF_8000_0000);
    step(i_type(12'h03F, 5'd11, 3'b001, 5'd15));
    check("slli63", xr(15), 64'h8000_0000_0000_0000);
    step(i_type(12'hFFF, 5'd0, 3'b011, 5'd16));
    check("sltiu", xr(16), 64'd1);
    // sra x17,x14,x11 : shift by 15
    step(r_type(7'b0100000, 5'd11, 5'd14, 3'b101, 5'd17));
    check("sra_reg", xr(17), 64'hFFFF_FFFF_FFFF_0000);
    // srl x18,x14,x11
    step(r_type(7'b0000000, 5'd11, 5'd14, 3'b101, 5'd18));
    check("srl_reg", xr(18), 64'h0001_FFFF_FFFF_0000);
    pc_before = pc_out;
    step(32'h0000_007F);
    check("illegal_pc", pc_out, pc_before + 64'd4);
    check("illegal_x0", xr(0), 64'd0);
    // slli with instr[31:26] != 0 must not write
    step(i_type(12'h401, 5'd9, 3'b001, 5'd14));
    check("bad_slli", xr(14), 64'hFFFF_FFFF_8000_0000);
    // OP with bad funct7 (and-form) must not write
    step(r_type(7'b0100000, 5'd6, 5'd7, 3'b111, 5'd8));
    check("bad_f7", xr(8), 64'h05);

    // 6: reset mid-run with a valid instruction present
    rst = 1'b1;
    step(32'h00C0_0293);
    rst = 1'b0;
    check("rst_pc", pc_out, 64'd0);
    begin
      int nz;
      nz = 0;
      for (int i = 0; i < 32; i++) if (xr(i) != 64'd0) nz++;
      check("rst_all_zero", 64'(nz), 64'd0);
    end
    step(32'h00C0_0293);
    check("resume_pc", pc_out, 64'd4);
    check("resume_x5", xr(5), 64'd12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/datapath.md
Name: datapath

Overview:
- Single-cycle RV64I integer datapath: executes one 32-bit instruction per clock, supplied directly on `instruction`.
- There is no instruction memory and no fetch stage. The external bench/fetch unit presents the instruction for the PC shown on `pc_out`.
- Holds the 64-bit PC and the 32x64 integer register file, and implements register-register and register-immediate ALU ops plus LUI.

Parameters:
- XLEN, 64, datapath/register width (fixed at 64 for RV64I).
- PC_STEP, 4, PC increment per executed instruction.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- instruction  input  32  instruction to execute this cycle, combinationally decoded.
- pc_out  output  64  current PC register value.

Behaviour:
- Reset: sampled only at the posedge of clk. While rst=1 at an edge:
  - PC <= 0; all X[0..31] <= 0.
  - No register write occurs; reset has priority over any instruction.
- Normal cycle (rst=0), at each posedge:
  - PC <= PC + 4. Wraps modulo 2^64.
  - If the instruction is supported and rd != 0: X[rd] <= ALU result.
- pc_out is the PC register (registered output). After reset it reads 0.
- Register file:
  - Instance name REGFILE, storage array named X[0:31], 64 bits each.
  - Two combinational read ports (rs1 = instr[19:15], rs2 = instr[24:20]).
  - One synchronous write port (rd = instr[11:7]).
  - X[0] reads 0 always and is never written.
  - Read-during-write in the same cycle returns the old value; the new value is visible after the edge.
- Decode by opcode instr[6:0]:
  - 0010011 OP-IMM: imm = sign-extended instr[31:20]. funct3 selects:
    - 000 ADDI, 010 SLTI, 011 SLTIU, 100 XORI, 110 ORI, 111 ANDI.
    - 001 SLLI: shamt = instr[25:20], instr[31:26] must be 0.
    - 101: SRLI when instr[31:26]=000000, SRAI when 010000.
  - 0110011 OP, funct7/funct3:
    - 0000000/000 ADD, 0100000/000 SUB.
    - 001 SLL, 010 SLT, 011 SLTU, 100 XOR.
    - 0000000/101 SRL, 0100000/101 SRA.
    - 110 OR, 111 AND.
  - 0110111 LUI: X[rd] <= sign-extended {instr[31:12], 12'b0}.
- Arithmetic and width rules:
  - Full 64-bit, two's complement; overflow is ignored.
  - Shift amount: rs2[5:0] for register shifts, instr[25:20] for immediate shifts.
  - SLT/SLTI compare signed; SLTU/SLTIU compare unsigned. Result is 0 or 1.
- Unsupported or illegal encodings (unknown opcode or funct combination): no register write, PC still advances by 4. No trap.
- Latency: one cycle. The result is visible in X[rd] and pc_out immediately after the edge that executes the instruction.

Decomposition:
- Shared package `rv64i_pkg`:
  - opcode constants (OPC_OP, OPC_OP_IMM, OPC_LUI);
  - funct3/funct7 constants;
  - alu_op_e enum (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASSB);
  - XLEN constant.
- Sub-module `regfile` (instance name REGFILE, array X): 32x64, 2R1W, synchronous reset clears all entries.
- Decoder, immediate generator and ALU stay inline in datapath.

Test Plan:
1. rst=1 for one edge, then 0x00C00293 (addi x5,x0,12) for one edge -> X[5]=12, pc_out=4.
2. After reset: 0x00500093 (addi x1,x0,5), 0x00600113 (addi x2,x0,6), 0x002081B3 (add x3,x1,x2), one edge each -> X[3]=11, pc_out=12.
3. x6=15, x7=5 via addi, then 0x40638233 (sub x4,x7,x6) -> X[4]=0xFFFFFFFFFFFFFFF6, pc_out=12.
4. Logic ops: x6=0x0F, x7=0x55, then and x8,x7,x6 -> X[8]=0x05. Then x20=0xF0, x21=0x55, or x20,x21,x20 -> X[20]=0xF5.
5. Edge cases:
   - addi x0,x0,7 -> X[0]=0.
   - addi x9,x0,-1 -> X[9]=all ones.
   - srai x10,x9,4 -> all ones; srli x11,x9,60 -> 0xF.
   - slt x12,x9,x0 -> 1; sltu x13,x9,x0 -> 0.
   - lui x14,0x80000 -> 0xFFFFFFFF80000000.
   - unknown opcode 0x0000007F -> no register changes, pc_out += 4.
6. Reset mid-run: execute three instructions, then hold rst=1 with a valid addi present -> after the edge pc_out=0, all X=0, no write. Release rst -> execution resumes from pc_out=0 and pc_out=4 after the next edge.
